hub75_bcm_scanner: RTL
======================

Name: hub75_bcm_scanner

Overview:
- Parametrised HUB75 panel scan engine with binary-coded-modulation (BCM) colour depth, global brightness and double-buffer swap handshake.
- Reads upper/lower row pairs from a synchronous framebuffer read port and shifts one bit plane per pass.
- Latches each plane and gates OE for a plane-weighted time.
- Sits between the SPI-fed framebuffer RAM and the panel pins; replaces the fixed 64x32, 4-bit scanner.

Parameters:
- WIDTH, 64, panel columns (power of two, >=4).
- ROWS, 32, panel rows (power of two, >=4); ROWS/2 scan lines.
- BPC, 4, bits per colour channel = number of bit planes (1..8).
- BASE_TICKS, 8, pixel_clk cycles of display period for plane 0; plane p lasts BASE_TICKS<<p.

Ports:
- pixel_clk  in  1  sole clock.
- n_reset  in  1  asynchronous active-low reset.
- fb_addr  out  log2(ROWS/2)+log2(WIDTH)  read address {line, col}.
- fb_select  out  1  which framebuffer half is displayed.
- fb_data  in  6*BPC  read data 1 cycle after fb_addr: {top R,G,B, bottom R,G,B}, each BPC bits, MSB first.
- brightness  in  8  global brightness; 255 = full.
- swap_req  in  1  level request to swap buffers at the next frame end.
- swap_ack  out  1  one-cycle pulse when the swap occurs.
- frame_start  out  1  one-cycle pulse at start of line 0 plane 0 shift.
- hub75_red, hub75_green, hub75_blue  out  2 each  bit0 = top half, bit1 = bottom half.
- hub75_addr  out  log2(ROWS/2)  scan line.
- hub75_clk  out  1  shift clock.
- hub75_latch  out  1  latch strobe, active high.
- hub75_oe  out  1  output enable, active low.

Behaviour:
- Reset, asynchronous: rgb=0, hub75_clk=0, hub75_latch=0, hub75_oe=1, hub75_addr=0, fb_addr=0, fb_select=0, swap_ack=0, frame_start=0. Internal line=0, plane=0, state=SHIFT. Reset mid-frame aborts immediately, with no partial latch.
- States: SHIFT -> BLANK -> LATCH -> DISPLAY -> NEXT -> SHIFT.
- SHIFT lasts 1 prefetch cycle + 2*WIDTH cycles:
  - Prefetch cycle: fb_addr={line,0}.
  - Each column c: phase A drives rgb = bit (BPC-1-plane)... more precisely bit index plane of each channel from fb_data, hub75_clk=0, fb_addr advances to c+1; phase B holds rgb with hub75_clk=1.
  - hub75_oe stays 1 throughout.
- BLANK (1 cycle): hub75_oe=1; hub75_addr<=line. hub75_addr only changes here.
- LATCH (1 cycle): hub75_latch=1, hub75_clk=0.
- DISPLAY lasts exactly P=BASE_TICKS<<plane cycles:
  - on = (P*(brightness+1))>>8, computed at full width with no overflow.
  - hub75_oe=0 for the first `on` cycles, then 1 for the remainder.
  - on=0 means OE never asserts for that plane.
- NEXT (1 cycle), wrap rules:
  - plane++; at BPC-1, plane wraps to 0 and line++.
  - When line wraps from ROWS/2-1 to 0 (frame end): if swap_req=1, toggle fb_select and pulse swap_ack the same cycle. swap_req still high at the next frame end swaps again.
- Brightness is sampled at frame_start and held constant for the frame.
- Plane order: 0 (LSB) to BPC-1 within each line.
- Frame length = (ROWS/2) * sum over p of (2*WIDTH+4 + BASE_TICKS<<p) cycles.

Optional Feature:
- Macro: HUB75_BCM_SCANNER_TEST_PATTERN_EN.
- Defined: adds input test_en (1 bit). When high, fb_data is ignored and each channel value = col[BPC-1:0] for both halves (column gradient). fb_addr still sequences normally.
- Undefined: no port; data always comes from fb_data.

Test Plan:
- Reset check: WIDTH=4, ROWS=4, BPC=2, BASE_TICKS=2; assert n_reset low mid-SHIFT -> all outputs at reset values within the same cycle, hub75_oe=1; first frame_start 1 cycle after release.
- Shift/latch: fb_data all bits 1 -> per plane exactly 4 hub75_clk rising edges, rgb=2'b11, then 1 latch pulse; hub75_addr changes only while hub75_oe=1.
- BCM weighting: brightness=255 -> OE low 2 cycles for plane 0 and 4 cycles for plane 1; frame length 2*(12+2+12+4)=60 cycles.
- Brightness: brightness=127 -> OE low 1 and 2 cycles; brightness=0 -> 0 and 0 (OE never low); period lengths unchanged.
- Swap: swap_req=1 mid-frame -> fb_select toggles and swap_ack pulses exactly at the line 1->0 wrap; swap_req dropped after ack -> no further toggle.
- With HUB75_BCM_SCANNER_TEST_PATTERN_EN and test_en=1: plane-0 shifted red bits = 0,1,0,1 for columns 0..3.

Source files
------------

// File: rtl/hub75_bcm_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : hub75_bcm_scanner
// Description : HUB75 panel scan engine with binary-coded-modulation colour
//               depth, global brightness and framebuffer double-buffer swap.
//               For every scan line and bit plane it reads the upper/lower
//               row pair from a synchronous framebuffer, shifts one bit plane
//               into the panel, latches it and gates OE for a plane-weighted
//               time scaled by the brightness captured at frame start.
//
// Ports       : pixel_clk    - sole clock
//               n_reset      - asynchronous active-low reset
//               fb_addr      - framebuffer read address {line, col}
//               fb_select    - framebuffer half being displayed
//               fb_data      - read data one cycle after fb_addr,
//                              {top R,G,B, bottom R,G,B}, BPC bits each
//               brightness   - global brightness, 255 = full
//               swap_req     - level request to swap buffers at frame end
//               swap_ack     - one-cycle pulse when the swap happens
//               frame_start  - one-cycle pulse at line 0 / plane 0 shift
//               hub75_red/green/blue - bit0 = top half, bit1 = bottom half
//               hub75_addr   - scan line
//               hub75_clk    - shift clock
//               hub75_latch  - latch strobe, active high
//               hub75_oe     - output enable, active low
//               test_en      - (HUB75_BCM_SCANNER_TEST_PATTERN_EN only)
//                              replaces fb_data with a column gradient
//
// Build macro : HUB75_BCM_SCANNER_TEST_PATTERN_EN adds the test_en input.
//
// Revision    : 1.0 - initial parameterised release
// ============================================================================
module hub75_bcm_scanner #(
    parameter int WIDTH      = 64,
    parameter int ROWS       = 32,
    parameter int BPC        = 4,
    parameter int BASE_TICKS = 8,
    localparam int c_LINES   = ROWS / 2,
    localparam int c_LINE_W  = $clog2(c_LINES),
    localparam int c_COL_W   = $clog2(WIDTH)
) (
    input  logic                         pixel_clk,
    input  logic                         n_reset,
    output logic [c_LINE_W+c_COL_W-1:0]  fb_addr,
    output logic                         fb_select,
    input  logic [6*BPC-1:0]             fb_data,
    input  logic [7:0]                   brightness,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         frame_start,
`ifdef HUB75_BCM_SCANNER_TEST_PATTERN_EN
    input  logic                         test_en,
`endif
    output logic [1:0]                   hub75_red,
    output logic [1:0]                   hub75_green,
    output logic [1:0]                   hub75_blue,
    output logic [c_LINE_W-1:0]          hub75_addr,
    output logic                         hub75_clk,
    output logic                         hub75_latch,
    output logic                         hub75_oe
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int c_PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int c_SCNT_W  = $clog2(2 * WIDTH + 1);
    localparam int c_PER_W   = $clog2((BASE_TICKS << (BPC - 1)) + 1);
    // period * 256 must fit without overflow
    localparam int c_PROD_W  = c_PER_W + 9;

    localparam logic [2:0] c_ST_SHIFT   = 3'd0;
    localparam logic [2:0] c_ST_BLANK   = 3'd1;
    localparam logic [2:0] c_ST_LATCH   = 3'd2;
    localparam logic [2:0] c_ST_DISPLAY = 3'd3;
    localparam logic [2:0] c_ST_NEXT    = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]                  r_state;
    logic [c_SCNT_W-1:0]         r_scnt;      // 0 = prefetch, odd = phase A, even = phase B
    logic [c_PER_W-1:0]          r_dcnt;      // display cycle index
    logic [c_LINE_W-1:0]         r_line;
    logic [c_PLANE_W-1:0]        r_plane;
    logic [7:0]                  r_bright;

    logic [c_LINE_W+c_COL_W-1:0] r_fb_addr;
    logic                        r_fb_select;
    logic                        r_swap_ack;
    logic                        r_frame_start;
    logic [1:0]                  r_red;
    logic [1:0]                  r_green;
    logic [1:0]                  r_blue;
    logic [c_LINE_W-1:0]         r_hub_addr;
    logic                        r_hub_clk;
    logic                        r_latch;
    logic                        r_oe;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [c_COL_W-1:0]  w_col;
    logic [5:0]          w_fb_bits;     // {topR,topG,topB,botR,botG,botB} at plane
    logic [5:0]          w_bits;
    logic [c_PER_W-1:0]  w_period;
    logic [c_PROD_W-1:0] w_prod;
    logic [c_PROD_W-1:0] w_on;
    logic [c_PROD_W-1:0] w_dnext;
    logic                w_plane_wrap;
    logic                w_line_wrap;
    logic [c_LINE_W-1:0] w_line_next;

    // During phase A (r_scnt = 2c+1) the column being shifted is r_scnt >> 1.
    assign w_col = r_scnt[c_COL_W:1];

    // Channel k of fb_data: k=5 top R ... k=0 bottom B, MSB first per channel.
    for (genvar k = 0; k < 6; k++) begin : g_chan
        logic [BPC-1:0] w_ch;
        assign w_ch         = fb_data[k*BPC +: BPC];
        assign w_fb_bits[k] = w_ch[r_plane];
    end

`ifdef HUB75_BCM_SCANNER_TEST_PATTERN_EN
    // Column gradient: every channel carries col[BPC-1:0], zero-extended
    // when the column index is narrower than the colour depth.
    logic [BPC-1:0] w_tp_val;
    for (genvar b = 0; b < BPC; b++) begin : g_tp
        if (b < c_COL_W) begin : g_in
            assign w_tp_val[b] = w_col[b];
        end else begin : g_out
            assign w_tp_val[b] = 1'b0;
        end
    end
    assign w_bits = test_en ? {6{w_tp_val[r_plane]}} : w_fb_bits;
`else
    assign w_bits = w_fb_bits;
`endif

    // Display period and the brightness-scaled OE-on time for this plane.
    assign w_period = c_PER_W'(BASE_TICKS) << r_plane;
    assign w_prod   = c_PROD_W'(w_period) * c_PROD_W'({1'b0, r_bright} + 9'd1);
    assign w_on     = w_prod >> 8;
    assign w_dnext  = c_PROD_W'(r_dcnt) + c_PROD_W'(1);

    assign w_plane_wrap = (r_plane == c_PLANE_W'(BPC - 1));
    assign w_line_wrap  = (r_line == c_LINE_W'(c_LINES - 1));
    assign w_line_next  = w_plane_wrap ? (w_line_wrap ? '0 : r_line + c_LINE_W'(1))
                                       : r_line;

    // ------------------------------------------------------------------------
    // Scan state machine; every panel and framebuffer output is a flop.
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= c_ST_SHIFT;
            r_scnt        <= '0;
            r_dcnt        <= '0;
            r_line        <= '0;
            r_plane       <= '0;
            r_bright      <= 8'd0;
            r_fb_addr     <= '0;
            r_fb_select   <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_frame_start <= 1'b0;
            r_red         <= 2'b00;
            r_green       <= 2'b00;
            r_blue        <= 2'b00;
            r_hub_addr    <= '0;
            r_hub_clk     <= 1'b0;
            r_latch       <= 1'b0;
            r_oe          <= 1'b1;
        end else begin
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
            case (r_state)
                c_ST_SHIFT: begin
                    r_oe    <= 1'b1;
                    r_latch <= 1'b0;
                    if (r_scnt == '0) begin
                        // Prefetch cycle: fb_addr already holds {line, 0}.
                        if (r_line == '0 && r_plane == '0) begin
                            r_frame_start <= 1'b1;
                            r_bright      <= brightness;
                        end
                        r_scnt <= r_scnt + c_SCNT_W'(1);
                    end else if (r_scnt[0]) begin
                        // Phase A: present data with clock low, fetch next column.
                        r_red     <= {w_bits[2], w_bits[5]};
                        r_green   <= {w_bits[1], w_bits[4]};
                        r_blue    <= {w_bits[0], w_bits[3]};
                        r_hub_clk <= 1'b0;
                        r_fb_addr <= {r_line, w_col + c_COL_W'(1)};
                        r_scnt    <= r_scnt + c_SCNT_W'(1);
                    end else begin
                        // Phase B: rising shift clock with data held.
                        r_hub_clk <= 1'b1;
                        if (r_scnt == c_SCNT_W'(2 * WIDTH)) begin
                            r_scnt  <= '0;
                            r_state <= c_ST_BLANK;
                        end else begin
                            r_scnt <= r_scnt + c_SCNT_W'(1);
                        end
                    end
                end

                c_ST_BLANK: begin
                    // OE is high here, so the row address may move safely.
                    r_oe       <= 1'b1;
                    r_hub_addr <= r_line;
                    r_hub_clk  <= 1'b0;
                    r_latch    <= 1'b1;
                    r_state    <= c_ST_LATCH;
                end

                c_ST_LATCH: begin
                    r_latch <= 1'b0;
                    r_dcnt  <= '0;
                    r_oe    <= (w_on == '0);
                    r_state <= c_ST_DISPLAY;
                end

                c_ST_DISPLAY: begin
                    if (r_dcnt == w_period - c_PER_W'(1)) begin
                        r_oe    <= 1'b1;
                        r_state <= c_ST_NEXT;
                    end else begin
                        r_dcnt <= r_dcnt + c_PER_W'(1);
                        r_oe   <= !(w_dnext < w_on);
                    end
                end

                c_ST_NEXT: begin
                    r_oe      <= 1'b1;
                    r_scnt    <= '0;
                    r_fb_addr <= {w_line_next, {c_COL_W{1'b0}}};
                    r_line    <= w_line_next;
                    if (w_plane_wrap) begin
                        r_plane <= '0;
                        if (w_line_wrap && swap_req) begin
                            r_fb_select <= ~r_fb_select;
                            r_swap_ack  <= 1'b1;
                        end
                    end else begin
                        r_plane <= r_plane + c_PLANE_W'(1);
                    end
                    r_state <= c_ST_SHIFT;
                end

                default: begin
                    r_state <= c_ST_SHIFT;
                    r_scnt  <= '0;
                    r_oe    <= 1'b1;
                    r_latch <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign fb_addr     = r_fb_addr;
    assign fb_select   = r_fb_select;
    assign swap_ack    = r_swap_ack;
    assign frame_start = r_frame_start;
    assign hub75_red   = r_red;
    assign hub75_green = r_green;
    assign hub75_blue  = r_blue;
    assign hub75_addr  = r_hub_addr;
    assign hub75_clk   = r_hub_clk;
    assign hub75_latch = r_latch;
    assign hub75_oe    = r_oe;

endmodule
`default_nettype wire
